// File: rtl/uart_rx_ctrl.sv
// UART receive control: synchronizes the serial line, qualifies start bits, issues
// mid-bit shift strobes to an external shift register and holds the received word.
module uart_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS:0]   packet_data,
  output logic                 shift_strobe,
  output logic                 rx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  input  logic                 data_read,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 2);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] WRAP_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, RECV, CHECK} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [1:0]           sync_valid_q, sync_valid_d;
  logic                 line_armed_q, line_armed_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;
  logic                 start_edge;

  // The synchronizer resets high, so a line held low through reset would look like
  // a falling edge; only arm edge detection once a real high sample has been seen.
  assign start_edge = line_armed_q & prev_q & ~sync2_q;

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    state_d      = state_q;
    sync1_d      = serial_in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    sync_valid_d = {sync_valid_q[0], 1'b1};
    line_armed_d = line_armed_q | (sync_valid_q[1] & sync2_q);
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
    shift_strobe = 1'b0;

    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_CNT) begin
          if (!sync2_q) begin
            state_d   = RECV;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            framing_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        // Strobe is decoded from the wrap so the shift lands on the mid-bit edge.
        if (clk_cnt_q == WRAP_CNT) begin
          clk_cnt_d    = '0;
          shift_strobe = 1'b1;
          bit_cnt_d    = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = CHECK;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (packet_data[DATA_BITS]) begin
          rx_data_d    = packet_data[DATA_BITS-1:0];
          data_ready_d = 1'b1;
          overrun_d    = data_ready_q & ~data_read;
        end else begin
          framing_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      sync_valid_q <= '0;
      line_armed_q <= 1'b0;
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      sync_valid_q <= sync_valid_d;
      line_armed_q <= line_armed_d;
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

  assign rx_bit        = sync2_q;
  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven frames, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS    = 8;
  localparam int CLKS_PER_BIT = 10;
  localparam int FRAME_BITS   = DATA_BITS + 2;
  localparam int NUM_STROBES  = DATA_BITS + 1;
  // Two synchronizer cycles, then half a bit to mid-start, then one full bit.
  localparam int FIRST_STROBE = 2 + CLKS_PER_BIT / 2 + CLKS_PER_BIT;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 stop;
    logic                 read_before;
    logic [DATA_BITS-1:0] exp_data;
    logic                 exp_ready;
    logic                 exp_ovr;
    logic                 exp_fe;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 serial_in = 1'b1;
  logic                 data_read = 1'b0;
  logic [DATA_BITS:0]   packet_data;
  logic                 shift_strobe;
  logic                 rx_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;
  logic [DATA_BITS:0]   sr_q;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   strobe_q[$];
  int   ready_rise = 0;
  logic ready_seen = 1'b0;

  uart_rx_ctrl #(.DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .packet_data   (packet_data),
    .shift_strobe  (shift_strobe),
    .rx_bit        (rx_bit),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .data_read     (data_read),
    .overrun_error (overrun_error),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Neighbouring serial-to-parallel register: new bit enters at the MSB.
  always @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '1;
    else if (shift_strobe) sr_q <= {rx_bit, sr_q[DATA_BITS:1]};
  end
  assign packet_data = sr_q;

  always @(negedge clk) begin
    if (shift_strobe) strobe_q.push_back(cyc);
    if (data_ready && !ready_seen) ready_rise <= cyc;
    ready_seen <= data_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] data, input logic stop,
                            input int nbits, input int read_at,
                            output int t0, output int s0);
    logic [FRAME_BITS-1:0] bits;
    bits = {stop, data, 1'b0};
    s0   = strobe_q.size();
    t0   = 0;
    for (int k = 0; k < nbits * CLKS_PER_BIT; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) t0 = cyc;
      serial_in = bits[k / CLKS_PER_BIT];
      data_read = (k == read_at);
    end
    if (nbits == FRAME_BITS) begin
      @(posedge clk);
      #1;
      serial_in = 1'b1;
      data_read = 1'b0;
    end
  endtask

  task automatic pulse_read();
    @(posedge clk);
    #1 data_read = 1'b1;
    @(posedge clk);
    #1 data_read = 1'b0;
  endtask

  task automatic check_outputs(input logic [DATA_BITS-1:0] exp_data, input logic exp_ready,
                               input logic exp_ovr, input logic exp_fe);
    check("rx_data", 32'(rx_data), 32'(exp_data));
    check("data_ready", 32'(data_ready), 32'(exp_ready));
    check("overrun_error", 32'(overrun_error), 32'(exp_ovr));
    check("framing_error", 32'(framing_error), 32'(exp_fe));
  endtask

  task automatic run_frame(input logic [DATA_BITS-1:0] data, input logic stop, input int read_at,
                           input logic [DATA_BITS-1:0] exp_data, input logic exp_ready,
                           input logic exp_ovr, input logic exp_fe, input logic chk_latency);
    int t0, s0, n, bad;
    send_frame(data, stop, FRAME_BITS, read_at, t0, s0);
    repeat (3) @(posedge clk);
    #1;
    n = strobe_q.size() - s0;
    check("strobe_count", n, NUM_STROBES);
    if (n == NUM_STROBES) begin
      check("first_strobe_latency", strobe_q[s0] - t0, FIRST_STROBE);
      bad = 0;
      for (int j = 1; j < NUM_STROBES; j++)
        if (strobe_q[s0+j] - strobe_q[s0+j-1] != CLKS_PER_BIT) bad++;
      check("strobe_spacing_errors", bad, 0);
      if (chk_latency)
        check("ready_after_last_strobe", ready_rise - strobe_q[s0+NUM_STROBES-1], 2);
    end
    check_outputs(exp_data, exp_ready, exp_ovr, exp_fe);
  endtask

  task automatic glitch(input int len);
    int s0;
    s0 = strobe_q.size();
    @(posedge clk);
    #1 serial_in = 1'b0;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("glitch_strobes", strobe_q.size() - s0, 0);
  endtask

  vec_t                 vecs[9];
  logic                 prev_ready;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_ready, m_ovr, m_fe, m_was_ready;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_stop;
  int                   t0, s0;

  initial begin
    //          data   stop  rd_b  exp_data rdy   ovr   fe
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};

    // Reset values.
    #1 rst = 1'b1;
    #1;
    check("reset_shift_strobe", 32'(shift_strobe), 0);
    check("reset_rx_bit", 32'(rx_bit), 1);
    check_outputs('0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);

    // Table-driven frames.
    prev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].read_before) begin
        pulse_read();
        check("read_clears_ready", 32'(data_ready), 0);
        check("read_clears_overrun", 32'(overrun_error), 0);
        prev_ready = 1'b0;
      end
      run_frame(vecs[i].data, vecs[i].stop, -1, vecs[i].exp_data, vecs[i].exp_ready,
                vecs[i].exp_ovr, vecs[i].exp_fe, vecs[i].stop & ~prev_ready);
      prev_ready = vecs[i].exp_ready;
    end

    // data_read in the CHECK cycle (last strobe + 1) of a loading frame: load wins.
    run_frame(8'h55, 1'b1, FIRST_STROBE + (NUM_STROBES - 1) * CLKS_PER_BIT + 1,
              8'h55, 1'b1, 1'b0, 1'b0, 1'b0);

    // Short low glitch on an idle line.
    glitch(3);
    check_outputs(8'h55, 1'b1, 1'b0, 1'b0);

    // Reset after the 4th strobe with the line held low.
    send_frame(8'hC3, 1'b1, 5, -1, t0, s0);
    check("strobes_before_reset", strobe_q.size() - s0, 4);
    serial_in = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_shift_strobe", 32'(shift_strobe), 0);
    check("midreset_rx_bit", 32'(rx_bit), 1);
    check_outputs('0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("low_line_after_reset_strobes", strobe_q.size() - s0, 4);
    check("low_line_after_reset_ready", 32'(data_ready), 0);
    serial_in = 1'b1;
    repeat (6) @(posedge clk);
    run_frame(8'h0F, 1'b1, -1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized frames against a frame-level reference model.
    m_data  = 8'h0F;
    m_ready = 1'b1;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(2, 12)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
      r_data      = DATA_BITS'($urandom);
      r_stop      = ($urandom_range(0, 3) != 0);
      m_was_ready = m_ready;
      if (r_stop) begin
        m_ovr   = m_ready;
        m_ready = 1'b1;
        m_data  = r_data;
        m_fe    = 1'b0;
      end else begin
        m_fe = 1'b1;
      end
      run_frame(r_data, r_stop, -1, m_data, m_ready, m_ovr, m_fe, r_stop & ~m_was_ready);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
